// File: rtl/ball_engine.sv
// Tick-paced two-player ball game engine on a WIDTH x WIDTH matrix (SERVE/PLAY/POINT/OVER).
// Optional macro PADDLE_SPIN_EN: a paddle hit sets dx from which paddle cell the ball struck.
module ball_engine #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int STEP_TICKS   = 4,
    parameter int SERVE_TICKS  = 8,
    parameter int HOLD_TICKS   = 8,
    parameter int WIN_SCORE    = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    top_left,
    input  logic                    top_right,
    input  logic                    down_left,
    input  logic                    down_right,
    input  logic                    start,
    output logic [BIT_OF_WIDTH-1:0] x_pos,
    output logic [BIT_OF_WIDTH-1:0] y_pos,
    output logic [2:0]              player_top,
    output logic [2:0]              player_down,
    output logic [3:0]              score_top,
    output logic [3:0]              score_down,
    output logic                    game_over
);
    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

    localparam logic [BIT_OF_WIDTH-1:0] X_MAX    = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] X_SERVE  = BIT_OF_WIDTH'(WIDTH / 2 - 1);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_TOP  = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] ROW_DOWN = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [BIT_OF_WIDTH-1:0] ONE      = BIT_OF_WIDTH'(1);
    localparam logic [2:0] PAD_MAX    = 3'(WIDTH - 2);
    localparam logic [2:0] PAD_INIT   = 3'(WIDTH / 2 - 1);
    localparam logic [3:0] SERVE_LAST = 4'(SERVE_TICKS - 1);
    localparam logic [3:0] STEP_LAST  = 4'(STEP_TICKS - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_TICKS - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [BIT_OF_WIDTH-1:0] x_reg, x_next, y_reg, y_next;
    // Direction bits: 1 means +1, 0 means -1
    logic                    dx_reg, dx_next, dy_reg, dy_next;
    logic                    serve_dx_reg, serve_dx_next;
    logic [1:0][2:0]         pad_reg, pad_next, pad_moved;   // [0] top, [1] down
    logic [3:0]              score_top_reg, score_top_next, score_down_reg, score_down_next;
    logic                    game_over_reg, game_over_next;

    logic [1:0] left_btn, right_btn;
    assign left_btn  = {down_left, top_left};
    assign right_btn = {down_right, top_right};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_paddle
            assign pad_moved[gi] =
                (left_btn[gi] && !right_btn[gi] && pad_reg[gi] != 3'd0)    ? pad_reg[gi] - 3'd1 :
                (right_btn[gi] && !left_btn[gi] && pad_reg[gi] != PAD_MAX) ? pad_reg[gi] + 3'd1 :
                                                                              pad_reg[gi];
        end
    endgenerate

    logic                    chk_top, chk_down, at_left, at_right, hit, miss;
    logic                    dx_hit, wall, dx_step, dy_step;
    logic [BIT_OF_WIDTH-1:0] pad_l, pad_r, x_step, y_step;

    // Paddle test uses pre-move positions; paddle and wall reflections combine in one step
    always_comb begin
        chk_top  = (y_reg == ROW_TOP) && !dy_reg;
        chk_down = (y_reg == ROW_DOWN) && dy_reg;
        pad_l    = BIT_OF_WIDTH'(chk_top ? pad_reg[0] : pad_reg[1]);
        pad_r    = pad_l + ONE;
        at_left  = (x_reg == pad_l);
        at_right = (x_reg == pad_r);
        hit      = (chk_top || chk_down) && (at_left || at_right);
        miss     = (chk_top || chk_down) && !hit;
`ifdef PADDLE_SPIN_EN
        dx_hit   = hit ? at_right : dx_reg;
`else
        dx_hit   = dx_reg;
`endif
        wall     = (x_reg == '0 && !dx_hit) || (x_reg == X_MAX && dx_hit);
        dx_step  = wall ? ~dx_hit : dx_hit;
        dy_step  = hit ? ~dy_reg : dy_reg;
        x_step   = dx_step ? x_reg + ONE : x_reg - ONE;
        y_step   = dy_step ? y_reg + ONE : y_reg - ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SERVE;
            cnt_reg        <= '0;
            x_reg          <= X_SERVE;
            y_reg          <= ROW_TOP;
            dx_reg         <= 1'b1;
            dy_reg         <= 1'b1;
            serve_dx_reg   <= 1'b1;
            pad_reg        <= {PAD_INIT, PAD_INIT};
            score_top_reg  <= '0;
            score_down_reg <= '0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            dx_reg         <= dx_next;
            dy_reg         <= dy_next;
            serve_dx_reg   <= serve_dx_next;
            pad_reg        <= pad_next;
            score_top_reg  <= score_top_next;
            score_down_reg <= score_down_next;
            game_over_reg  <= game_over_next;
        end
    end

    logic [3:0] score_top_inc, score_down_inc;
    logic       down_missed;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        dx_next         = dx_reg;
        dy_next         = dy_reg;
        serve_dx_next   = serve_dx_reg;
        pad_next        = pad_reg;
        score_top_next  = score_top_reg;
        score_down_next = score_down_reg;
        score_top_inc   = score_top_reg + 4'd1;
        score_down_inc  = score_down_reg + 4'd1;
        down_missed     = (y_reg == X_MAX);

        if (state_reg == OVER) begin
            if (start) begin
                state_next      = SERVE;
                cnt_next        = '0;
                x_next          = X_SERVE;
                y_next          = ROW_TOP;
                dx_next         = 1'b1;
                dy_next         = 1'b1;
                serve_dx_next   = 1'b1;
                score_top_next  = '0;
                score_down_next = '0;
            end
        end else if (tick) begin
            case (state_reg)
                SERVE: begin
                    pad_next = pad_moved;
                    if (cnt_reg == SERVE_LAST) begin
                        state_next = PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                PLAY: begin
                    pad_next = pad_moved;
                    if (cnt_reg == STEP_LAST) begin
                        cnt_next = '0;
                        x_next   = x_step;
                        y_next   = y_step;
                        dx_next  = dx_step;
                        dy_next  = dy_step;
                        if (miss)
                            state_next = POINT;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                POINT: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_next = '0;
                        if (down_missed)
                            score_top_next = score_top_inc;
                        else
                            score_down_next = score_down_inc;
                        if ((down_missed ? score_top_inc : score_down_inc) == WIN) begin
                            state_next = OVER;
                        end else begin
                            // The player who conceded serves from their own row
                            state_next    = SERVE;
                            serve_dx_next = ~serve_dx_reg;
                            dx_next       = ~serve_dx_reg;
                            x_next        = X_SERVE;
                            y_next        = down_missed ? ROW_DOWN : ROW_TOP;
                            dy_next       = ~down_missed;
                        end
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
        game_over_next = (state_next == OVER);
    end

    assign x_pos       = x_reg;
    assign y_pos       = y_reg;
    assign player_top  = pad_reg[0];
    assign player_down = pad_reg[1];
    assign score_top   = score_top_reg;
    assign score_down  = score_down_reg;
    assign game_over   = game_over_reg;
endmodule
